// File: rtl/bus_trace_checker.sv
// bus_trace_checker: watches CPU bus writes and compares them, in order, against a
// programmed table of expected (address, data) pairs; reports pass / fail / timeout.
module bus_trace_checker #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     clear,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_odata,
    input  logic                     bus_rw,
    input  logic                     bus_strobe,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH)-1:0] fail_index,
    output logic [DATA_W-1:0]        fail_data,
    output logic [$clog2(DEPTH):0]   entries
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW:0]   FULL_E   = (IW + 1)'(DEPTH);
    localparam logic [IW:0]   ONE_E    = (IW + 1)'(1);
    localparam logic [IW-1:0] ONE_P    = IW'(1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_DATA = 2'b01;
    localparam logic [1:0] CODE_ADDR = 2'b10;
    localparam logic [1:0] CODE_TMO  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_tab_addr [DEPTH];
    logic [DATA_W-1:0] r_tab_data [DEPTH];

    logic [IW:0]       r_entries;
    logic [IW-1:0]     r_ptr;
    logic [CW-1:0]     r_tcnt;

    logic              r_done;
    logic              r_pass;
    logic              r_fail;
    logic [1:0]        r_fail_code;
    logic [IW-1:0]     r_fail_index;
    logic [DATA_W-1:0] r_fail_data;

    logic              w_write_ev;
    logic              w_addr_hit;
    logic              w_data_hit;
    logic              w_match;
    logic              w_last;
    logic              w_expired;
    logic              w_load_ok;
    logic [1:0]        w_code;

    logic              w_pass_nxt;
    logic              w_fail_nxt;
    logic [1:0]        w_fail_code_nxt;
    logic [IW-1:0]     w_fail_index_nxt;
    logic [DATA_W-1:0] w_fail_data_nxt;

    assign w_write_ev = (r_state == ST_RUN) && bus_strobe && !bus_rw;
    assign w_addr_hit = (bus_addr == r_tab_addr[r_ptr]);
    assign w_data_hit = (bus_odata == r_tab_data[r_ptr]);
    assign w_match    = w_write_ev && w_addr_hit && w_data_hit;
    assign w_last     = (({1'b0, r_ptr} + ONE_E) == r_entries);
    assign w_expired  = (r_tcnt == TMO_LAST);
    // start takes precedence over a same-cycle load; a full table drops the load
    assign w_load_ok  = (r_state == ST_IDLE) && load_en && !start && !clear &&
                        (r_entries != FULL_E);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; write-event failures outrank a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_code      = CODE_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (r_entries == '0) ? ST_PASS : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_write_ev && w_addr_hit && !w_data_hit) begin
                    w_state_nxt = ST_FAIL;
                    w_code      = CODE_DATA;
                end else if (w_write_ev && !w_addr_hit && (STRICT != 0)) begin
                    w_state_nxt = ST_FAIL;
                    w_code      = CODE_ADDR;
                end else if (w_match && w_last) begin
                    w_state_nxt = ST_PASS;
                end else if (!w_match && w_expired) begin
                    w_state_nxt = ST_FAIL;
                    w_code      = CODE_TMO;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PASS: w_state_nxt = ST_PASS;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_code      = CODE_NONE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Output decode: status follows the next state, failure details captured on entry to FAIL
    always_comb begin
        w_pass_nxt       = (w_state_nxt == ST_PASS);
        w_fail_nxt       = (w_state_nxt == ST_FAIL);
        w_fail_code_nxt  = r_fail_code;
        w_fail_index_nxt = r_fail_index;
        w_fail_data_nxt  = r_fail_data;
        if (clear) begin
            w_fail_code_nxt  = CODE_NONE;
            w_fail_index_nxt = '0;
            w_fail_data_nxt  = '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_FAIL)) begin
            w_fail_code_nxt  = w_code;
            w_fail_index_nxt = r_ptr;
            w_fail_data_nxt  = (w_code == CODE_TMO) ? '0 : bus_odata;
        end else begin
            w_fail_code_nxt  = r_fail_code;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_code  <= CODE_NONE;
            r_fail_index <= '0;
            r_fail_data  <= '0;
        end else begin
            r_done       <= w_pass_nxt | w_fail_nxt;
            r_pass       <= w_pass_nxt;
            r_fail       <= w_fail_nxt;
            r_fail_code  <= w_fail_code_nxt;
            r_fail_index <= w_fail_index_nxt;
            r_fail_data  <= w_fail_data_nxt;
        end
    end

    // Table fill count, check pointer and inactivity counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entries <= '0;
            r_ptr     <= '0;
            r_tcnt    <= '0;
        end else if (clear) begin
            r_entries <= '0;
            r_ptr     <= '0;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr  <= '0;
                        r_tcnt <= '0;
                    end else if (w_load_ok) begin
                        r_entries <= r_entries + ONE_E;
                    end else begin
                        r_entries <= r_entries;
                    end
                end
                ST_RUN: begin
                    if (w_match) begin
                        r_ptr  <= r_ptr + ONE_P;
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + ONE_C;
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    // Table storage; contents are don't-care until loaded
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_tab_addr[r_entries[IW-1:0]] <= load_addr;
            r_tab_data[r_entries[IW-1:0]] <= load_data;
        end else begin
            r_tab_addr[r_entries[IW-1:0]] <= r_tab_addr[r_entries[IW-1:0]];
        end
    end

    assign done       = r_done;
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign fail_code  = r_fail_code;
    assign fail_index = r_fail_index;
    assign fail_data  = r_fail_data;
    assign entries    = r_entries;

endmodule

// File: tb/tb_bus_trace_checker.sv
// Bench for bus_trace_checker: a strict and a lenient instance share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_bus_trace_checker;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int TMO   = 16;
    localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic load_en = 1'b0, clear = 1'b0, start = 1'b0;
    logic bus_rw = 1'b1, bus_strobe = 1'b0;
    logic [AW-1:0] load_addr = '0, bus_addr = '0;
    logic [DW-1:0] load_data = '0, bus_odata = '0;

    logic          dut_done [2];
    logic          dut_pass [2];
    logic          dut_fail [2];
    logic [1:0]    dut_code [2];
    logic [IW-1:0] dut_fidx [2];
    logic [DW-1:0] dut_fdata[2];
    logic [IW:0]   dut_ent  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    int m_state[2], m_idx[2], m_mark[2], m_code[2], m_fidx[2], m_fdata[2];
    int cyc = 0;

    always #5 clk = ~clk;

    bus_trace_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(1)) u_strict (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .clear(clear), .start(start), .bus_addr(bus_addr),
        .bus_odata(bus_odata), .bus_rw(bus_rw), .bus_strobe(bus_strobe),
        .done(dut_done[0]), .pass(dut_pass[0]), .fail(dut_fail[0]), .fail_code(dut_code[0]),
        .fail_index(dut_fidx[0]), .fail_data(dut_fdata[0]), .entries(dut_ent[0]));

    bus_trace_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(0)) u_lenient (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .clear(clear), .start(start), .bus_addr(bus_addr),
        .bus_odata(bus_odata), .bus_rw(bus_rw), .bus_strobe(bus_strobe),
        .done(dut_done[1]), .pass(dut_pass[1]), .fail(dut_fail[1]), .fail_code(dut_code[1]),
        .fail_index(dut_fidx[1]), .fail_data(dut_fdata[1]), .entries(dut_ent[1]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        for (int s = 0; s < 2; s++) begin
            m_state[s] = S_IDLE; m_idx[s] = 0; m_mark[s] = 0;
            m_code[s] = 0; m_fidx[s] = 0; m_fdata[s] = 0;
        end
    endtask

    task automatic model_fail(input int s, input int code, input int data);
        m_state[s] = S_FAIL;
        m_code[s]  = code;
        m_fidx[s]  = m_idx[s];
        m_fdata[s] = data;
    endtask

    // one rising edge of the reference model, using the inputs seen at that edge
    task automatic model_edge();
        bit was_idle;
        cyc++;
        if (!reset_n || clear) begin
            model_reset();
            return;
        end
        was_idle = (m_state[0] == S_IDLE);
        for (int s = 0; s < 2; s++) begin
            if (m_state[s] == S_IDLE) begin
                if (start) begin
                    m_state[s] = (q_addr.size() == 0) ? S_PASS : S_RUN;
                    m_idx[s]   = 0;
                    m_mark[s]  = cyc;
                end
            end else if (m_state[s] == S_RUN) begin
                if (bus_strobe && !bus_rw) begin
                    if (bus_addr == q_addr[m_idx[s]]) begin
                        if (bus_odata == q_data[m_idx[s]]) begin
                            m_idx[s]++;
                            m_mark[s] = cyc;
                            if (m_idx[s] == q_addr.size()) m_state[s] = S_PASS;
                        end else begin
                            model_fail(s, 1, int'(bus_odata));
                        end
                    end else if (s == 0) begin
                        model_fail(s, 2, int'(bus_odata));
                    end
                end
                // no progress for TMO edges since RUN entry or the last match
                if (m_state[s] == S_RUN && (cyc - m_mark[s]) == TMO) model_fail(s, 3, 0);
            end
        end
        if (was_idle && load_en && !start && q_addr.size() < DEPTH) begin
            q_addr.push_back(load_addr);
            q_data.push_back(load_data);
        end
    endtask

    task automatic check_all();
        string nm;
        bit fin;
        for (int s = 0; s < 2; s++) begin
            nm  = (s == 0) ? "strict" : "lenient";
            fin = (m_state[s] == S_PASS) || (m_state[s] == S_FAIL);
            check_val({nm, ".done"},       32'(dut_done[s]),  32'(fin));
            check_val({nm, ".pass"},       32'(dut_pass[s]),  32'(m_state[s] == S_PASS));
            check_val({nm, ".fail"},       32'(dut_fail[s]),  32'(m_state[s] == S_FAIL));
            check_val({nm, ".fail_code"},  32'(dut_code[s]),  32'(m_code[s]));
            check_val({nm, ".fail_index"}, 32'(dut_fidx[s]),  32'(m_fidx[s]));
            check_val({nm, ".fail_data"},  32'(dut_fdata[s]), 32'(m_fdata[s]));
            check_val({nm, ".entries"},    32'(dut_ent[s]),   32'(q_addr.size()));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_idle();
        bus_strobe = 1'b0; bus_rw = 1'b1; bus_addr = '0; bus_odata = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1; cycle(); clear = 1'b0;
    endtask

    task automatic load_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d; cycle(); load_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic bus_cyc(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_strobe = 1'b1; bus_rw = rw; bus_addr = a; bus_odata = d;
        cycle();
        bus_idle();
    endtask

    // LDA #$55 / EOR #$55 / STA $99 as seen on the bus
    task automatic run_lda_eor_sta(input logic [DW-1:0] store_val);
        bus_cyc(1'b1, 16'h0200, 8'hA9); bus_cyc(1'b1, 16'h0201, 8'h55);
        bus_cyc(1'b1, 16'h0202, 8'h49); bus_cyc(1'b1, 16'h0203, 8'h55);
        bus_cyc(1'b1, 16'h0204, 8'h85); bus_cyc(1'b1, 16'h0205, 8'h99);
        bus_cyc(1'b0, 16'h0099, store_val);
    endtask

    initial begin
        int n;
        int dens;
        int j;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check_all();
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();

        // store of 0x00 to $99 matches
        load_entry(16'h0099, 8'h00);
        do_start();
        run_lda_eor_sta(8'h00);
        check_val("plan_pass.done", 32'(dut_done[0]), 32'd1);
        check_val("plan_pass.code", 32'(dut_code[0]), 32'd0);

        // wrong data to the right address
        do_clear();
        load_entry(16'h0099, 8'h00);
        do_start();
        run_lda_eor_sta(8'h55);
        check_val("data_mis.code", 32'(dut_code[0]), 32'd1);
        check_val("data_mis.fdata", 32'(dut_fdata[0]), 32'h55);

        // unexpected address first: strict fails, lenient skips it
        do_clear();
        load_entry(16'h0099, 8'h12);
        do_start();
        bus_cyc(1'b0, 16'h0100, 8'h12);
        check_val("addr_mis.code", 32'(dut_code[0]), 32'd2);
        bus_cyc(1'b0, 16'h0099, 8'h12);
        check_val("lenient_skip.pass", 32'(dut_pass[1]), 32'd1);

        // timeout lands exactly TMO cycles after RUN entry
        do_clear();
        load_entry(16'h0099, 8'h00);
        do_start();
        n = 0;
        while (!dut_fail[0] && n < 40) begin
            cycle();
            n++;
        end
        check_val("timeout.cycles", 32'(n), 32'(TMO));
        check_val("timeout.code", 32'(dut_code[0]), 32'd3);

        // a match on the expiry cycle beats the timeout
        do_clear();
        load_entry(16'h0099, 8'h00);
        do_start();
        for (int i = 0; i < TMO - 1; i++) cycle();
        bus_cyc(1'b0, 16'h0099, 8'h00);
        check_val("expiry_match.pass", 32'(dut_pass[0]), 32'd1);

        // overfill, empty start, start+load collision
        do_clear();
        for (int i = 0; i < DEPTH + 2; i++) load_entry(16'(16'h0300 + i), 8'(i));
        check_val("overfill.entries", 32'(dut_ent[0]), 32'(DEPTH));
        do_clear();
        do_start();
        check_val("empty_start.pass", 32'(dut_pass[0]), 32'd1);
        do_clear();
        load_entry(16'h0010, 8'h01);
        load_en = 1'b1; load_addr = 16'h0011; load_data = 8'h02;
        do_start();
        load_en = 1'b0;
        check_val("start_load.entries", 32'(dut_ent[0]), 32'd1);

        // asynchronous reset in the middle of RUN
        do_clear();
        load_entry(16'h0020, 8'h01);
        load_entry(16'h0021, 8'h02);
        do_start();
        bus_cyc(1'b0, 16'h0020, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst.entries", 32'(dut_ent[0]), 32'd0);
        check_val("async_rst.done", 32'(dut_done[1]), 32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();

        // clear out of FAIL, then a fresh sequence
        load_entry(16'h0040, 8'hAA);
        do_start();
        bus_cyc(1'b0, 16'h0040, 8'hAB);
        do_clear();
        check_val("clear_fail.fail", 32'(dut_fail[0]), 32'd0);
        load_entry(16'h0041, 8'h5A);
        do_start();
        bus_cyc(1'b0, 16'h0041, 8'h5A);
        check_val("fresh.pass", 32'(dut_pass[0]), 32'd1);

        // randomized trials, small address/data alphabet so matches are common
        for (int t = 0; t < 40; t++) begin
            do_clear();
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++)
                load_entry(16'(16'h0090 + $urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            do_start();
            dens = $urandom_range(1, 7);
            for (int k = 0; k < 45; k++) begin
                bus_strobe = ($urandom_range(0, 7) < dens);
                bus_rw     = ($urandom_range(0, 3) == 0);
                j = (m_idx[1] < q_addr.size()) ? m_idx[1] : 0;
                bus_addr   = ($urandom_range(0, 3) != 0) ? q_addr[j] : 16'(16'h0090 + $urandom_range(0, 3));
                bus_odata  = ($urandom_range(0, 3) != 0) ? q_data[j] : 8'($urandom_range(0, 3));
                load_en    = ($urandom_range(0, 15) == 0);
                start      = ($urandom_range(0, 15) == 0);
                cycle();
            end
            bus_idle();
            load_en = 1'b0;
            start   = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/bus_trace_checker.md
Name: bus_trace_checker

Overview:
- Synthesizable self-checking monitor that watches the cpu6502 bus and compares each CPU write (rw == 0) against a programmed, ordered table of expected (address, data) pairs.
- Parametrised successor to per-test fixed-cycle bus assertions. Write checks are keyed to write order, not absolute cycle counts, so one bench serves many instruction tests. Adds a timeout and a strict/lenient match mode.
- Sits beside cpu6502 in test harnesses and on-FPGA smoke tests. Drives pass/fail/done status.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.
- DEPTH, 8, expected-write table entries (power of two, >= 2).
- TIMEOUT, 1024, cycles allowed in RUN before failing.
- STRICT, 1, 1 = every write must match the next entry; 0 = non-matching writes are ignored (subsequence match).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_en  in  1  append one entry to table (IDLE only).
- load_addr  in  ADDR_W  expected write address.
- load_data  in  DATA_W  expected write data.
- clear  in  1  empty table, return to IDLE.
- start  in  1  begin checking (IDLE only).
- bus_addr  in  ADDR_W  CPU address bus.
- bus_odata  in  DATA_W  CPU write data.
- bus_rw  in  1  CPU read/write, 0 = write.
- bus_strobe  in  1  sample qualifier, one cycle per bus cycle (rising edge of clk2).
- done  out  1  checking finished (PASS or FAIL).
- pass  out  1  all entries matched in order.
- fail  out  1  mismatch or timeout.
- fail_code  out  2  00 none, 01 data mismatch, 10 address mismatch (STRICT), 11 timeout.
- fail_index  out  log2(DEPTH)  table index being checked at failure.
- fail_data  out  DATA_W  bus_odata captured at failure (0 on timeout).
- entries  out  log2(DEPTH)+1  current table fill count.

Behaviour:
- Reset (async, reset_n low): state IDLE; table count and pointers 0; all outputs 0. Table contents need not be cleared.
- States: IDLE, RUN, PASS, FAIL.
- Loading (IDLE, load_en=1):
  - Entry written at index entries; entries increments next cycle.
  - load_en when entries == DEPTH is ignored. Table is unchanged and entries saturates at DEPTH.
  - load_en in RUN, PASS or FAIL is ignored.
- clear: highest priority after reset, in any state. Next cycle: IDLE, entries = 0, all status cleared.
- start (IDLE): next cycle RUN with check pointer = 0 and timeout counter = 0.
  - If entries == 0, go directly to PASS instead.
  - start and load_en in the same cycle: start wins, load dropped.
- Write event: RUN && bus_strobe && !bus_rw. Reads and unstrobed cycles are never checked.
- On a write event, compare against entry[ptr]:
  - addr and data equal: ptr++. If ptr was entries-1, go to PASS next cycle.
  - addr equal, data differs: FAIL, code 01.
  - addr differs, STRICT=1: FAIL, code 10.
  - addr differs, STRICT=0: ignore the write and stay at ptr.
  - On any FAIL: capture fail_index = ptr and fail_data = bus_odata.
- Timeout:
  - Counter increments every cycle in RUN and resets to 0 on each matching write.
  - Reaching TIMEOUT-1 with no match goes to FAIL, code 11.
  - A match in the same cycle as expiry wins; no timeout is raised.
- PASS/FAIL are sticky until clear or reset. done = pass | fail. Outputs are registered, so status appears 1 cycle after the deciding edge.
- start in PASS/FAIL is ignored; clear is required first.
- Reset asserted mid-RUN: immediate IDLE, table emptied.

Test Plan:
- Load (0x0099,0x00), start, run LDA #$55 / EOR #$55 / STA $99 -> pass=1, fail_code=00, done 1 cycle after the STA strobe.
- Load (0x0099,0x00), CPU stores 0x55 to $99 -> fail=1, fail_code=01, fail_index=0, fail_data=0x55.
- STRICT=1, load (0x0099,x), CPU first writes $0100 -> fail_code=10. STRICT=0, same stimulus -> write ignored, later $99 match gives pass=1.
- TIMEOUT=16, one entry, no CPU writes -> fail_code=11 exactly 16 cycles after RUN entry. Variant: a matching write on the expiry cycle -> pass=1.
- Load DEPTH+2 entries -> entries=DEPTH, extra entries dropped. start with entries=0 -> pass=1 next cycle. load_en with start in the same cycle -> entries unchanged.
- Pull reset_n low mid-RUN, asynchronously -> outputs 0 without a clock edge. clear in FAIL -> IDLE, entries=0, a fresh load/start sequence works.
